adder_result_queue: RTL and testbench

- Downstream companion of the pipelined prefix adder (32-bit a, b, carry-in -> sum, cout, fixed pipeline latency).
- Tracks an issue-valid bit and destination tag alongside the adder pipeline, and captures each {sum, cout} when it emerges.
- Buffers captured results in a small FIFO and hands them to writeback over a valid/ready handshake.
- Applies credit-based back-pressure on issue so that no result leaving the adder is ever dropped, since the adder cannot stall.

---
 rtl/adder_result_queue.sv | 137 +++++++++++++
 tb/tb_adder_result_queue.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_result_queue.sv
// Result queue behind the fixed-latency prefix adder. Tags ride a delay line next to the adder pipe, and results land in a FIFO.
// Latency: an issue at edge t is captured at edge t+LATENCY. With the FIFO empty, res_valid rises right after that edge.
// Backpressure: valid/ready toward writeback; issue_ready hands out credits so an arrival never meets a full FIFO.
// Ports: clock/reset_n (async, active low); issue_valid/issue_tag/issue_ready (issue side);
//        sum/cout (adder outputs); res_valid/res_ready/res_sum/res_cout/res_zero/res_tag (writeback side);
//        occupancy (entries stored); drop_err (sticky: an arrival was lost to a full FIFO).
module adder_result_queue #(
  parameter int WIDTH   = 32,
  parameter int TAG_W   = 5,
  parameter int LATENCY = 5,
  parameter int DEPTH   = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     issue_valid,
  input  logic [TAG_W-1:0]         issue_tag,
  output logic                     issue_ready,
  input  logic [WIDTH-1:0]         sum,
  input  logic                     cout,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_sum,
  output logic                     res_cout,
  output logic                     res_zero,
  output logic [TAG_W-1:0]         res_tag,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     drop_err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             zero;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [LATENCY-1:0] line_vld;
  logic [TAG_W-1:0]   line_tag [LATENCY];
  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               accept;
  logic               arrival;
  logic               full;
  logic               push;
  logic               pop;
  entry_t             arr_entry;
  entry_t             head;
  int                 inflight;

  assign accept  = issue_valid && issue_ready;
  assign arrival = line_vld[LATENCY-1];
  assign full    = (count == CNT_W'(DEPTH));
  assign push    = arrival && !full;
  assign pop     = res_valid && res_ready;

  // The delay line mirrors the adder pipe. It never stalls, because the adder cannot stall either.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      line_vld <= '0;
    end else begin
      line_vld[0] <= accept;
      for (int i = 1; i < LATENCY; i++) begin
        line_vld[i] <= line_vld[i-1];
      end
    end
  end

  // Tags are only meaningful next to a set valid bit, so they need no reset.
  always_ff @(posedge clock) begin
    line_tag[0] <= issue_tag;
    for (int i = 1; i < LATENCY; i++) begin
      line_tag[i] <= line_tag[i-1];
    end
  end

  // The zero flag is computed once, at capture, so the output side stays a plain register read.
  assign arr_entry.sum  = sum;
  assign arr_entry.cout = cout;
  assign arr_entry.zero = (sum == '0);
  assign arr_entry.tag  = line_tag[LATENCY-1];

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= arr_entry;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Only reachable if the credit loop is broken, e.g. LATENCY does not match the adder.
      if (arrival && full) begin
        drop_err <= 1'b1;
      end
    end
  end

  // Every set valid bit in the delay line is a FIFO slot that is already promised.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + int'(line_vld[i]);
    end
  end

  // Uses registered state only. A pop frees its credit on the following cycle.
  assign issue_ready = (int'(count) + inflight) < DEPTH;

  assign res_valid = (count != '0);
  // Storage is not reset, so the head fields are forced to zero while the FIFO is empty.
  assign head      = res_valid ? mem[rd_ptr] : '0;
  assign res_sum   = head.sum;
  assign res_cout  = head.cout;
  assign res_zero  = head.zero;
  assign res_tag   = head.tag;
  assign occupancy = count;

endmodule

// File: tb/tb_adder_result_queue.sv
module tb_adder_result_queue;
  localparam int W  = 32;
  localparam int TW = 5;
  localparam int L  = 5;
  localparam int D  = 4;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            issue_valid;
  logic [TW-1:0]   issue_tag;
  logic            issue_ready;
  logic [W-1:0]    sum;
  logic            cout;
  logic            res_valid;
  logic            res_ready;
  logic [W-1:0]    res_sum;
  logic            res_cout;
  logic            res_zero;
  logic [TW-1:0]   res_tag;
  logic [2:0]      occupancy;
  logic            drop_err;

  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic            cin;
  logic [W:0]      add_pipe [L];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  adder_result_queue #(.WIDTH(W), .TAG_W(TW), .LATENCY(L), .DEPTH(D)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .issue_valid (issue_valid),
    .issue_tag   (issue_tag),
    .issue_ready (issue_ready),
    .sum         (sum),
    .cout        (cout),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_sum     (res_sum),
    .res_cout    (res_cout),
    .res_zero    (res_zero),
    .res_tag     (res_tag),
    .occupancy   (occupancy),
    .drop_err    (drop_err)
  );

  // Behavioural stand-in for the adder: operands sampled at edge t, sum visible after edge t+L-1.
  always @(posedge clock) begin
    add_pipe[0] <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    for (int i = 1; i < L; i++) begin
      add_pipe[i] <= add_pipe[i-1];
    end
  end
  assign sum  = add_pipe[L-1][W-1:0];
  assign cout = add_pipe[L-1][W];

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          c;
    logic [TW-1:0] tag;
    logic [W-1:0]  exp_sum;
    logic          exp_cout;
    logic          exp_zero;
  } vec_t;

  vec_t         vecs [6];
  logic [W-1:0] bp_exp [4];
  logic [W-1:0] s_a [20];
  logic [W-1:0] s_b [20];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                       input logic op_c, input logic [TW-1:0] tag);
    issue_valid = 1'b1;
    a           = op_a;
    b           = op_b;
    cin         = op_c;
    issue_tag   = tag;
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    @(posedge clock);
    #3;
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tx;
    int rx;
    int cyc;

    vecs[0] = '{32'd10,       32'd20,       1'b0, 5'd3,  32'd30,       1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'd1,        1'b0, 5'd7,  32'd0,        1'b1, 1'b1};
    vecs[2] = '{32'hFFFFFFFF, 32'd0,        1'b1, 5'd31, 32'd0,        1'b1, 1'b1};
    vecs[3] = '{32'h7FFFFFFF, 32'd1,        1'b0, 5'd0,  32'h80000000, 1'b0, 1'b0};
    vecs[4] = '{32'd0,        32'd0,        1'b0, 5'd18, 32'd0,        1'b0, 1'b1};
    vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5'd12, 32'hFFFFFFFF, 1'b1, 1'b0};
    bp_exp  = '{32'd46, 32'd125, 32'd907, 32'd12};
    s_a[0] = 32'd123; s_b[0] = 32'd787;
    s_a[1] = 32'd15;  s_b[1] = 32'd72;
    s_a[2] = 32'd55;  s_b[2] = 32'd71;
    s_a[3] = 32'd52;  s_b[3] = 32'd17;
    for (int i = 4; i < 20; i++) begin
      s_a[i] = 32'(i * 1000 + 7);
      s_b[i] = 32'(i * 333);
    end

    reset_n     = 1'b0;
    issue_valid = 1'b0;
    issue_tag   = '0;
    res_ready   = 1'b0;
    a           = '0;
    b           = '0;
    cin         = 1'b0;

    // Reset state
    #12;
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_drop_err",  64'(drop_err),  64'd0);
    check("rst_res_sum",   64'(res_sum),   64'd0);
    check("rst_res_cout",  64'(res_cout),  64'd0);
    check("rst_res_zero",  64'(res_zero),  64'd0);
    check("rst_res_tag",   64'(res_tag),   64'd0);
    #6;
    reset_n = 1'b1;
    tick();
    check("rst_issue_ready", 64'(issue_ready), 64'd1);

    // Single operations from the table: latency, fields, one-cycle valid pulse
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("vec%0d_ready", i), 64'(issue_ready), 64'd1);
      drive(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].tag);
      tick();
      issue_valid = 1'b0;
      repeat (L - 1) tick();
      check($sformatf("vec%0d_early", i), 64'(res_valid), 64'd0);
      tick();
      check($sformatf("vec%0d_valid", i), 64'(res_valid), 64'd1);
      check($sformatf("vec%0d_sum", i),   64'(res_sum),   64'(vecs[i].exp_sum));
      check($sformatf("vec%0d_cout", i),  64'(res_cout),  64'(vecs[i].exp_cout));
      check($sformatf("vec%0d_zero", i),  64'(res_zero),  64'(vecs[i].exp_zero));
      check($sformatf("vec%0d_tag", i),   64'(res_tag),   64'(vecs[i].tag));
      check($sformatf("vec%0d_occ", i),   64'(occupancy), 64'd1);
      tick();
      check($sformatf("vec%0d_pulse", i), 64'(res_valid), 64'd0);
    end

    // Back-pressure: four credits, a fifth issue held off
    res_ready = 1'b0;
    drive(32'd14, 32'd32, 1'b0, 5'd1);
    check("bp_ready0", 64'(issue_ready), 64'd1);
    tick();
    drive(32'd56, 32'd68, 1'b1, 5'd2);
    check("bp_ready1", 64'(issue_ready), 64'd1);
    tick();
    drive(32'd156, 32'd750, 1'b1, 5'd3);
    check("bp_ready2", 64'(issue_ready), 64'd1);
    tick();
    drive(32'd5, 32'd7, 1'b0, 5'd4);
    check("bp_ready3", 64'(issue_ready), 64'd1);
    tick();
    drive(32'd1, 32'd1, 1'b0, 5'd5);
    check("bp_ready_after4", 64'(issue_ready), 64'd0);
    repeat (L) tick();
    check("bp_occ_full", 64'(occupancy), 64'd4);
    check("bp_held", 64'(issue_ready), 64'd0);
    issue_valid = 1'b0;
    res_ready   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_valid%0d", i), 64'(res_valid), 64'd1);
      check($sformatf("bp_sum%0d", i),   64'(res_sum),   64'(bp_exp[i]));
      check($sformatf("bp_tag%0d", i),   64'(res_tag),   64'(i + 1));
      tick();
      if (i == 0) check("bp_ready_after_pop", 64'(issue_ready), 64'd1);
    end
    repeat (L + 1) tick();
    check("bp_no_fifth", 64'(res_valid), 64'd0);
    check("bp_drop_err", 64'(drop_err), 64'd0);

    // Streaming: issue whenever a credit exists; results must come out in order, never more than one buffered
    res_ready = 1'b1;
    tx  = 0;
    rx  = 0;
    cyc = 0;
    while (rx < 20 && cyc < 400) begin
      if (res_valid) begin
        check($sformatf("st_sum%0d", rx), 64'(res_sum), 64'(s_a[rx] + s_b[rx]));
        check($sformatf("st_tag%0d", rx), 64'(res_tag), 64'(rx[TW-1:0]));
        check($sformatf("st_occ%0d", rx), 64'(occupancy <= 3'd1), 64'd1);
        rx++;
      end
      if (tx < 20) begin
        drive(s_a[tx], s_b[tx], 1'b0, 5'(tx));
        if (issue_ready) tx++;
      end else begin
        issue_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    issue_valid = 1'b0;
    check("st_all_results", 64'(rx), 64'd20);
    repeat (L + 1) tick();
    check("st_no_extra", 64'(res_valid), 64'd0);

    // Asynchronous reset with two results buffered and two in flight
    res_ready = 1'b0;
    drive(32'd1, 32'd1, 1'b0, 5'd1);
    tick();
    drive(32'd2, 32'd2, 1'b0, 5'd2);
    tick();
    issue_valid = 1'b0;
    repeat (L) tick();
    check("rm_occ2", 64'(occupancy), 64'd2);
    drive(32'd3, 32'd3, 1'b0, 5'd3);
    tick();
    drive(32'd4, 32'd4, 1'b0, 5'd4);
    tick();
    issue_valid = 1'b0;
    check("rm_no_credit", 64'(issue_ready), 64'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("rm_valid_async", 64'(res_valid),   64'd0);
    check("rm_occ_async",   64'(occupancy),   64'd0);
    check("rm_ready_async", 64'(issue_ready), 64'd1);
    @(posedge clock);
    #3;
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < L + 2; i++) begin
      check($sformatf("rm_stale%0d", i), 64'(res_valid), 64'd0);
      tick();
    end
    res_ready = 1'b1;
    drive(32'd5, 32'd7, 1'b0, 5'd9);
    tick();
    issue_valid = 1'b0;
    repeat (L - 1) tick();
    check("rm_post_early", 64'(res_valid), 64'd0);
    tick();
    check("rm_post_valid", 64'(res_valid), 64'd1);
    check("rm_post_sum",   64'(res_sum),   64'd12);
    check("rm_post_tag",   64'(res_tag),   64'd9);
    tick();
    check("rm_post_pulse", 64'(res_valid), 64'd0);

    // Forced arrival into a full FIFO
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(32'(100 + i), 32'(i), 1'b0, 5'(20 + i));
      tick();
    end
    issue_valid = 1'b0;
    repeat (L) tick();
    check("fm_occ_full", 64'(occupancy), 64'd4);
    check("fm_drop_pre", 64'(drop_err),  64'd0);
    force dut.line_vld = {1'b1, {(L-1){1'b0}}};
    tick();
    release dut.line_vld;
    check("fm_drop_set", 64'(drop_err),  64'd1);
    check("fm_occ_kept", 64'(occupancy), 64'd4);
    check("fm_head",     64'(res_sum),   64'd100);
    repeat (3) tick();
    check("fm_drop_sticky", 64'(drop_err),  64'd1);
    check("fm_occ_still",   64'(occupancy), 64'd4);
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fm_sum%0d", i), 64'(res_sum), 64'(100 + 2 * i));
      check($sformatf("fm_tag%0d", i), 64'(res_tag), 64'(20 + i));
      tick();
    end
    check("fm_drained",     64'(res_valid), 64'd0);
    check("fm_drop_remain", 64'(drop_err),  64'd1);
    do_reset();
    check("fm_drop_cleared", 64'(drop_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
